call_stack: RTL and testbench

- LIFO return-address store that services the subroutine unit's push/pop requests; it is the responder end of the call/ret push-pop interface.
- On CALL, the subroutine unit pushes PC+1. On RET, it consumes the top entry combinationally as the next PC in the same cycle, then pops it at the clock edge.
- Also provides sticky overflow/underflow error flags, a flush, and a high-water mark for debug.

---
 rtl/call_stack.sv | 114 +++++++++++
 tb/tb_call_stack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// LIFO return-address store for call/ret: push on CALL, combinational top read
// plus pop on RET, with sticky overflow/underflow flags, flush and high-water mark.
module call_stack #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 8,
    parameter int SP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    input  logic              flush,
    input  logic              err_clear,
    output logic [SP_W-1:0]   sp,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              overflow,
    output logic              underflow,
    output logic [SP_W-1:0]   high_water
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SP_W-1:0] sp_q, sp_next;
    logic [SP_W-1:0] hw_q, hw_next;
    logic            ovf_q, unf_q;
    logic            ovf_evt, unf_evt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   top_idx;
    logic            empty, full;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_W'(DEPTH));
    assign top_idx = AW'(sp_q - 1'b1);

    // Next-state decode: flush beats push/pop; push+pop replaces the top entry.
    always_comb begin
        sp_next = sp_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (flush) begin
            sp_next = '0;
        end else if (push && pop) begin
            wr_en = 1'b1;
            if (empty) begin
                wr_addr = '0;
                sp_next = SP_W'(1);
            end else begin
                wr_addr = top_idx;
            end
        end else if (push) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = AW'(sp_q);
                sp_next = sp_q + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                unf_evt = 1'b1;
            end else begin
                sp_next = sp_q - 1'b1;
            end
        end
    end

    always_comb begin
        hw_next = hw_q;
        if (flush) begin
            hw_next = '0;
        end else if (sp_next > hw_q) begin
            hw_next = sp_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            hw_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_next;
            hw_q  <= hw_next;
            // A new error event wins over a simultaneous clear.
            ovf_q <= ovf_evt | (ovf_q & ~err_clear);
            unf_q <= unf_evt | (unf_q & ~err_clear);
        end
    end

    // Storage is never reset; a write racing an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= push_data;
        end
    end

    assign pop_data    = empty ? '0 : mem[top_idx];
    assign sp          = sp_q;
    assign stack_empty = empty;
    assign stack_full  = full;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign high_water  = hw_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: hand-computed expectations for push/pop order,
// full/empty boundaries, replace-top, flush priority, sticky flags and async reset.
module tb_call_stack;

    localparam int DATA_W = 19;
    localparam int DEPTH  = 8;
    localparam int SP_W   = 4;

    logic              clk;
    logic              reset;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              flush;
    logic              err_clear;
    logic [SP_W-1:0]   sp;
    logic              stack_empty;
    logic              stack_full;
    logic              overflow;
    logic              underflow;
    logic [SP_W-1:0]   high_water;

    int checks = 0;
    int errors = 0;

    call_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SP_W(SP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (pop_data),
        .flush      (flush),
        .err_clear  (err_clear),
        .sp         (sp),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .overflow   (overflow),
        .underflow  (underflow),
        .high_water (high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; err_clear = 1'b0;
        push_data = '0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_sp", 32'(sp), 0);
        check("rst_empty", 32'(stack_empty), 1);
        check("rst_full", 32'(stack_full), 0);
        check("rst_pop_data", 32'(pop_data), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_hw", 32'(high_water), 0);

        // Three pushes then three pops, LIFO order
        push = 1'b1;
        push_data = 19'h00011; step();
        push_data = 19'h00022; step();
        push_data = 19'h00033; step();
        push = 1'b0;
        check("push3_sp", 32'(sp), 3);
        check("push3_top", 32'(pop_data), 32'h33);
        pop = 1'b1;
        #1 check("pop_a", 32'(pop_data), 32'h33);
        step();
        check("pop_b", 32'(pop_data), 32'h22);
        step();
        check("pop_c", 32'(pop_data), 32'h11);
        step();
        pop = 1'b0;
        check("pop3_sp", 32'(sp), 0);
        check("pop3_empty", 32'(stack_empty), 1);
        check("pop3_hw", 32'(high_water), 3);

        // Fill to DEPTH, then overflow
        push = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_data = 19'(32'h101 + i);
            step();
        end
        check("fill_full", 32'(stack_full), 1);
        check("fill_sp", 32'(sp), 8);
        check("fill_top", 32'(pop_data), 32'h108);
        check("fill_hw", 32'(high_water), 8);
        push_data = 19'h7FFFF;
        step();
        push = 1'b0;
        check("ovf_sp", 32'(sp), 8);
        check("ovf_top", 32'(pop_data), 32'h108);
        check("ovf_flag", 32'(overflow), 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("ovf_clear", 32'(overflow), 0);

        // Replace top while full
        push = 1'b1; pop = 1'b1; push_data = 19'h00300;
        step();
        push = 1'b0; pop = 1'b0;
        check("rep_full_sp", 32'(sp), 8);
        check("rep_full_top", 32'(pop_data), 32'h300);
        check("rep_full_ovf", 32'(overflow), 0);
        pop = 1'b1;
        step(); step(); step();
        pop = 1'b0;
        check("below_intact", 32'(pop_data), 32'h105);
        check("sp_5", 32'(sp), 5);

        // Flush beats a simultaneous push
        flush = 1'b1; push = 1'b1; push_data = 19'h00555;
        step();
        flush = 1'b0; push = 1'b0;
        check("flush_sp", 32'(sp), 0);
        check("flush_hw", 32'(high_water), 0);
        check("flush_pop_data", 32'(pop_data), 0);
        check("flush_ovf", 32'(overflow), 0);

        // Underflow on empty, set wins over clear
        pop = 1'b1;
        step();
        check("unf_sp", 32'(sp), 0);
        check("unf_flag", 32'(underflow), 1);
        check("unf_pop_data", 32'(pop_data), 0);
        err_clear = 1'b1;
        step();
        pop = 1'b0; err_clear = 1'b0;
        check("unf_set_wins", 32'(underflow), 1);
        check("unf_sp2", 32'(sp), 0);

        // Replace top at sp=2
        push = 1'b1;
        push_data = 19'h00080; step();
        push_data = 19'h00100; step();
        check("rep_pre_top", 32'(pop_data), 32'h100);
        pop = 1'b1; push_data = 19'h00200;
        step();
        push = 1'b0; pop = 1'b0;
        check("rep_sp", 32'(sp), 2);
        check("rep_top", 32'(pop_data), 32'h200);
        check("rep_ovf", 32'(overflow), 0);
        check("rep_hw", 32'(high_water), 2);
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("rep_below", 32'(pop_data), 32'h80);

        // Flush leaves sticky flags alone
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush2_sp", 32'(sp), 0);
        check("flush2_unf", 32'(underflow), 1);

        // Async reset mid-cycle with sp=4
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_data = 19'(32'h0A0 + i);
            step();
        end
        push = 1'b0;
        check("pre_rst_sp", 32'(sp), 4);
        check("pre_rst_hw", 32'(high_water), 4);
        #2 reset = 1'b1;
        #1;
        check("arst_sp", 32'(sp), 0);
        check("arst_empty", 32'(stack_empty), 1);
        check("arst_pop_data", 32'(pop_data), 0);
        check("arst_unf", 32'(underflow), 0);
        check("arst_hw", 32'(high_water), 0);
        step();
        reset = 1'b0;

        // push+pop on empty acts as plain push, no underflow
        push = 1'b1; pop = 1'b1; push_data = 19'h0004A;
        step();
        push = 1'b0; pop = 1'b0;
        check("pp_empty_sp", 32'(sp), 1);
        check("pp_empty_top", 32'(pop_data), 32'h4A);
        check("pp_empty_unf", 32'(underflow), 0);
        check("pp_empty_hw", 32'(high_water), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
